alu_seq: RTL and testbench

- Execute-stage sequencer that drives the team's 4-bit-opcode ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x32 register file.
- Drives the ALU op/tr/sr inputs, captures dr/cf, and writes the result back to the register file.
- Sits between the instruction source and the ALU; it owns the architectural registers and the carry flag.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_seq_if.sv | 15 +
 rtl/alu_regfile.sv | 52 +++++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_seq execute-stage sequencer.
//   - ALU opcode encodings (4-bit); anything above OP_LAST is illegal
//   - instruction word field positions:
//       [15:12] op, [11:9] rd, [8:6] rs, [5] imm_en, [4:0] imm5
//   - sequencer FSM state encoding
//   - small opcode classification helpers
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SLA  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_LAST = 4'd11;

  localparam int INSTR_W    = 16;
  localparam int OP_HI      = 15;
  localparam int OP_LO      = 12;
  localparam int RD_LO      = 9;
  localparam int RS_LO      = 6;
  localparam int IMM_EN_BIT = 5;
  localparam int IMM_HI     = 4;
  localparam int IMM_LO     = 0;
  localparam int IMM_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

  // Only the shift group updates the architectural carry flag.
  function automatic logic op_is_shift(input logic [3:0] op);
    return (op >= OP_SLL) && (op <= OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction delivery channel into the sequencer.
//   in_valid  source has an instruction word on in_instr
//   in_ready  sequencer can accept (transfer on in_valid && in_ready)
//   in_instr  16-bit instruction word, held by the source until accepted
// master = instruction source, slave = sequencer.
interface alu_seq_if;
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x XLEN architectural register file.
//   clk, rst                 clock, synchronous active-high clear of all entries
//   wb_we/wb_waddr/wb_wdata  writeback port (wins over host on the same entry)
//   host_we/_waddr/_wdata    host write port, honoured in any sequencer state
//   ra_addr/ra_data          combinational read (rd operand)
//   rb_addr/rb_data          combinational read (rs operand)
//   host_raddr/host_rdata    registered host read, one-cycle latency
module alu_regfile
  import alu_pkg::*;
#(
  parameter int  NREG = 8,
  parameter int  XLEN = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            host_we,
  input  logic [AW-1:0]   host_waddr,
  input  logic [XLEN-1:0] host_wdata,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic [AW-1:0]   host_raddr,
  output logic [XLEN-1:0] host_rdata
);

  logic [XLEN-1:0] mem [NREG];

  // No write-to-read bypass: readers only see writes from earlier edges.
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      host_rdata <= '0;
    end else begin
      // Per-entry select: both writers land when addresses differ,
      // writeback takes the entry when they collide.
      for (int i = 0; i < NREG; i++) begin
        if (wb_we && (wb_waddr == AW'(i)))          mem[i] <= wb_wdata;
        else if (host_we && (host_waddr == AW'(i))) mem[i] <= host_wdata;
      end
      host_rdata <= mem[host_raddr];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: execute-stage sequencer driving an external 4-bit-opcode ALU.
//   clk, rst        clock, synchronous active-high reset
//   ibus (slave)    instruction valid/ready channel (alu_seq_if)
//   alu_op/tr/sr    registered ALU inputs, held between instructions
//   alu_dr/cf/of    ALU result, shift carry-out, overflow (unused)
//   host_we/waddr/wdata, host_raddr/rdata   host access to the register file
//   cf_flag         architectural carry flag (shift ops only)
//   done / err      one-cycle pulses: retired / illegal opcode dropped
// Every instruction walks IDLE -> READ -> EXEC -> WB; no overlap.
module alu_seq
  import alu_pkg::*;
#(
  parameter int  NREG = 8,
  parameter int  XLEN = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  alu_seq_if.slave        ibus,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_tr,
  output logic [XLEN-1:0] alu_sr,
  input  logic [XLEN-1:0] alu_dr,
  input  logic            alu_cf,
  input  logic            alu_of,
  input  logic            host_we,
  input  logic [AW-1:0]   host_waddr,
  input  logic [XLEN-1:0] host_wdata,
  input  logic [AW-1:0]   host_raddr,
  output logic [XLEN-1:0] host_rdata,
  output logic            cf_flag,
  output logic            done,
  output logic            err
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [3:0]         op;
  logic [AW-1:0]      rd, rs;
  logic [XLEN-1:0]    rd_val, rs_val, imm_val, res_q;
  logic               cfq, legal, accept;
  logic               unused_of;

  assign unused_of = alu_of;

  assign op      = instr_q[OP_HI:OP_LO];
  assign rd      = instr_q[RD_LO +: AW];
  assign rs      = instr_q[RS_LO +: AW];
  assign imm_val = {{(XLEN-IMM_W){1'b0}}, instr_q[IMM_HI:IMM_LO]};
  assign legal   = op_legal(op);

  // Held low during reset so no handshake completes into a clearing FSM.
  assign ibus.in_ready = (state_q == IDLE) && !rst;
  assign accept        = ibus.in_valid && ibus.in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      alu_op  <= '0;
      alu_tr  <= '0;
      alu_sr  <= '0;
      cf_flag <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == EXEC);
      err     <= (state_q == READ) && !legal;
      // READ -> EXEC: operands registered so the ALU sees them stable all EXEC.
      if ((state_q == READ) && legal) begin
        alu_op <= op;
        alu_tr <= rd_val;
        alu_sr <= instr_q[IMM_EN_BIT] ? imm_val : rs_val;
      end
      // WB -> IDLE: carry becomes architectural for shifts only.
      if ((state_q == WB) && op_is_shift(op)) cf_flag <= cfq;
    end
  end

  // Datapath holding registers; reset-free since control gates their use.
  always_ff @(posedge clk) begin
    if (accept) instr_q <= ibus.in_instr;
    // EXEC -> WB: capture the combinational ALU result.
    if (state_q == EXEC) begin
      res_q <= alu_dr;
      cfq   <= alu_cf;
    end
  end

  alu_regfile #(.NREG(NREG), .XLEN(XLEN)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (state_q == WB),
    .wb_waddr   (rd),
    .wb_wdata   (res_q),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .ra_addr    (rd),
    .ra_data    (rd_val),
    .rb_addr    (rs),
    .rb_data    (rs_val),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural ALU attached.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  alu_op;
  logic [31:0] alu_tr, alu_sr, alu_dr;
  logic        alu_cf, alu_of;
  logic        host_we = 1'b0;
  logic [2:0]  host_waddr = '0, host_raddr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] host_rdata;
  logic        cf_flag, done, err;

  alu_seq_if ibus ();

  alu_seq #(.NREG(8), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ibus       (ibus),
    .alu_op     (alu_op),
    .alu_tr     (alu_tr),
    .alu_sr     (alu_sr),
    .alu_dr     (alu_dr),
    .alu_cf     (alu_cf),
    .alu_of     (alu_of),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .cf_flag    (cf_flag),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, result}; carry is the last bit shifted out.
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] r, t;
    logic [4:0]  sh;
    sh = b[4:0];
    r  = '0;
    t  = '0;
    case (op)
      OP_ADD, OP_CMP: r = {1'b0, 32'(a + b)};
      OP_SUB:         r = {1'b0, 32'(a - b)};
      OP_AND:         r = {1'b0, a & b};
      OP_OR:          r = {1'b0, a | b};
      OP_XOR:         r = {1'b0, a ^ b};
      OP_NEG:         r = {1'b0, 32'(32'd0 - a)};
      OP_NOT:         r = {1'b0, ~a};
      OP_SLL, OP_SLA: r = {1'b0, a} << sh;
      OP_SRL: begin
        t = {a, 1'b0} >> sh;
        r = {t[0], t[32:1]};
      end
      OP_SRA: begin
        t = 33'($signed({a, 1'b0}) >>> sh);
        r = {t[0], t[32:1]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // CMP is modelled as subtraction by the bench ALU
  function automatic logic [32:0] alu_bench(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    return (op == OP_CMP) ? {1'b0, 32'(a - b)} : alu_ref(op, a, b);
  endfunction

  assign {alu_cf, alu_dr} = alu_bench(alu_op, alu_tr, alu_sr);
  assign alu_of = ^alu_dr;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        is_err;
    logic [3:0]  op;
    logic [31:0] tr;
    logic [31:0] sr;
    logic        cf_after;
  } exp_t;

  exp_t        sb_q[$];
  int          acc_q[$];
  logic [31:0] m_reg [8];
  logic        m_cf = 1'b0;
  int          cyc = 0;
  int          last_acc = -1, prev_acc = -1;
  logic        cf_pend = 1'b0, rdy_pend = 1'b0, cf_exp = 1'b0;

  // Monitor: samples on the falling edge, pops the scoreboard on done/err.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    cyc++;
    if (rst) begin
      sb_q.delete();
      acc_q.delete();
      cf_pend  = 1'b0;
      rdy_pend = 1'b0;
    end else begin
      if (cf_pend) begin
        check("cf_flag", 32'(cf_flag), 32'(cf_exp));
        cf_pend = 1'b0;
      end
      if (rdy_pend) begin
        if (!ibus.in_valid) check("ready_after_err", 32'(ibus.in_ready), 32'd1);
        rdy_pend = 1'b0;
      end
      if (done || err) begin
        if (sb_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_retire", {30'd0, done, err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          a = acc_q.pop_front();
          check("retire_is_err", 32'(err), 32'(e.is_err));
          check("retire_is_done", 32'(done), 32'(!e.is_err));
          check("retire_latency", 32'(cyc - a), e.is_err ? 32'd2 : 32'd3);
          if (!e.is_err) begin
            check("alu_op", 32'(alu_op), 32'(e.op));
            check("alu_tr", alu_tr, e.tr);
            check("alu_sr", alu_sr, e.sr);
          end else begin
            rdy_pend = 1'b1;
          end
          cf_pend = 1'b1;
          cf_exp  = e.cf_after;
        end
      end
      if (ibus.in_valid && ibus.in_ready) begin
        acc_q.push_back(cyc);
        prev_acc = last_acc;
        last_acc = cyc;
      end
    end
  end

  // All driver tasks are entered and return 1 time unit after a rising edge.
  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic imm_en, input logic [4:0] imm);
    exp_t        e;
    logic [32:0] r;
    int          n;
    e.op     = op;
    e.is_err = (op > OP_LAST);
    e.tr     = m_reg[rd];
    e.sr     = imm_en ? {27'd0, imm} : m_reg[rs];
    if (!e.is_err) begin
      r         = alu_bench(op, e.tr, e.sr);
      m_reg[rd] = r[31:0];
      if (op >= OP_SLL) m_cf = r[32];
    end
    e.cf_after = m_cf;
    sb_q.push_back(e);
    ibus.in_valid = 1'b1;
    ibus.in_instr = {op, rd, rs, imm_en, imm};
    n = 0;
    @(negedge clk);
    while (!ibus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    ibus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !ibus.in_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    host_we    = 1'b1;
    host_waddr = a;
    host_wdata = d;
    m_reg[a]   = d;
    @(posedge clk);
    #1;
    host_we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    host_raddr = a;
    @(posedge clk);
    #1;
    check(tag, host_rdata, exp);
  endtask

  initial begin
    ibus.in_valid = 1'b0;
    ibus.in_instr = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ibus.in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_tr", alu_tr, 32'd0);
    check("rst_alu_sr", alu_sr, 32'd0);
    check("rst_cf_flag", 32'(cf_flag), 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ibus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // ADD r1 += r2
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    send(OP_ADD, 3'd1, 3'd2, 1'b0, 5'd0);
    wait_idle();
    check_reg("add_r1", 3'd1, 32'd8);
    check("add_cf", 32'(cf_flag), 32'd0);

    // Shift carries
    host_write(3'd3, 32'h8000_0000);
    send(OP_SLL, 3'd3, 3'd0, 1'b1, 5'd1);
    wait_idle();
    check_reg("sll_r3", 3'd3, 32'd0);
    check("sll_cf", 32'(cf_flag), 32'd1);
    host_write(3'd3, 32'd1);
    send(OP_SRL, 3'd3, 3'd0, 1'b1, 5'd1);
    wait_idle();
    check_reg("srl_r3", 3'd3, 32'd0);
    check("srl_cf", 32'(cf_flag), 32'd1);

    // Illegal opcode: dropped, no writeback, carry kept
    host_write(3'd3, 32'h1234_5678);
    send(4'b1100, 3'd3, 3'd1, 1'b0, 5'd0);
    wait_idle();
    check_reg("illegal_r3", 3'd3, 32'h1234_5678);
    check("illegal_cf", 32'(cf_flag), 32'd1);

    // Two queued ADDs back to back; the second sees the first's result
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd3);
    send(OP_ADD, 3'd1, 3'd2, 1'b0, 5'd0);
    send(OP_ADD, 3'd1, 3'd2, 1'b0, 5'd0);
    wait_idle();
    check("b2b_spacing", 32'(last_acc - prev_acc), 32'd4);
    check_reg("b2b_r1", 3'd1, 32'd11);

    // Random mix, including illegal opcodes, issued back to back
    for (int i = 0; i < 8; i++) host_write(3'(i), $urandom());
    for (int i = 0; i < 30; i++)
      send(4'($urandom_range(0, 13)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    wait_idle();
    for (int i = 0; i < 8; i++) check_reg("rand_reg", 3'(i), m_reg[i]);

    // Host write colliding with writeback on the same edge: writeback wins
    host_write(3'd1, 32'd10);
    host_write(3'd2, 32'd7);
    send(OP_ADD, 3'd1, 3'd2, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    host_we    = 1'b1;
    host_waddr = 3'd1;
    host_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    host_we = 1'b0;
    check_reg("collide_r1", 3'd1, 32'd17);
    wait_idle();

    // Reset during EXEC abandons the instruction
    send(OP_SUB, 3'd1, 3'd2, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_cf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_alu_op", 32'(alu_op), 32'd0);
    check("midrst_alu_tr", alu_tr, 32'd0);
    check("midrst_alu_sr", alu_sr, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(ibus.in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check_reg("midrst_r1", 3'd1, 32'd0);
    check("midrst_cf", 32'(cf_flag), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
